// File: rtl/l2_tlb_pkg.sv
// Purpose: shared constants, entry layout and FSM states for the L2 TLB access controller.
// Latency: n/a (types and pure helper functions only).
// Backpressure: n/a.
package l2_tlb_pkg;

    localparam int ENTRIES = 512;
    localparam int IDX_W   = 9;
    localparam int VPN_W   = 27;
    localparam int PPN_W   = 26;
    localparam int TAG_W   = VPN_W - IDX_W;
    localparam int ENTRY_W = 1 + TAG_W + PPN_W;

    // One RAM row, MSB first: valid, tag, ppn.
    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [PPN_W-1:0] ppn;
    } l2_tlb_entry_t;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        IDLE  = 2'd1,
        FLUSH = 2'd2
    } state_e;

    // Direct-mapped: low VPN bits select the row, the rest is stored as tag.
    function automatic logic [IDX_W-1:0] vpn_idx(input logic [VPN_W-1:0] vpn);
        return vpn[IDX_W-1:0];
    endfunction

    function automatic logic [TAG_W-1:0] vpn_tag(input logic [VPN_W-1:0] vpn);
        return vpn[VPN_W-1:IDX_W];
    endfunction

endpackage

// File: rtl/l2_tlb_ctrl.sv
// Purpose: access controller in front of the 512x45 single-port L2 TLB RAM: lookups, PTW refills, invalidate sweeps.
// Latency: lookup response exactly 2 cycles after acceptance; refill written on its acceptance edge; sweep 512 cycles.
// Backpressure: both readies low during INIT/FLUSH; priority flush > refill > lookup; responses cannot be stalled.
module l2_tlb_ctrl
    import l2_tlb_pkg::*;
(
    input  logic               clock,
    input  logic               reset_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [VPN_W-1:0]   req_vpn,
    output logic               resp_valid,
    output logic               resp_hit,
    output logic [PPN_W-1:0]   resp_ppn,
    input  logic               refill_valid,
    output logic               refill_ready,
    input  logic [VPN_W-1:0]   refill_vpn,
    input  logic [PPN_W-1:0]   refill_ppn,
    input  logic               flush_req,
    output logic               busy,
    output logic [IDX_W-1:0]   ram_addr,
    output logic               ram_en,
    output logic               ram_wmode,
    output logic [ENTRY_W-1:0] ram_wdata,
    input  logic [ENTRY_W-1:0] ram_rdata
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);

    state_e           r_state;
    logic [IDX_W-1:0] r_cnt;

    logic             r_s1_vld;
    logic [TAG_W-1:0] r_s1_tag;

    logic             r_resp_valid;
    logic             r_resp_hit;
    logic [PPN_W-1:0] r_resp_ppn;

    logic             w_idle;
    logic             w_refill_fire;
    logic             w_req_fire;
    logic             w_s1_hit;
    l2_tlb_entry_t    w_rd_entry;
    l2_tlb_entry_t    w_refill_entry;

    // Flush blocks everything in its cycle; a refill steals the port from a lookup.
    assign w_idle        = (r_state == IDLE);
    assign refill_ready  = w_idle & ~flush_req;
    assign req_ready     = w_idle & ~flush_req & ~refill_valid;
    assign w_refill_fire = refill_valid & refill_ready;
    assign w_req_fire    = req_valid & req_ready;
    assign busy          = ~w_idle;

    assign w_refill_entry = '{valid: 1'b1, tag: vpn_tag(refill_vpn), ppn: refill_ppn};
    assign w_rd_entry     = l2_tlb_entry_t'(ram_rdata);

    // ram_rdata belongs to the read issued last cycle, so compare against the tag captured with it.
    assign w_s1_hit = r_s1_vld & w_rd_entry.valid & (w_rd_entry.tag == r_s1_tag);

    assign resp_valid = r_resp_valid;
    assign resp_hit   = r_resp_hit;
    assign resp_ppn   = r_resp_ppn;

    // RAM port mux: sweep writes zeros (also while in reset: an idempotent write of row 0), else refill, else lookup read.
    always_comb begin
        ram_en    = 1'b0;
        ram_wmode = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (!w_idle) begin
            ram_en    = 1'b1;
            ram_wmode = 1'b1;
            ram_addr  = r_cnt;
        end else if (w_refill_fire) begin
            ram_en    = 1'b1;
            ram_wmode = 1'b1;
            ram_addr  = vpn_idx(refill_vpn);
            ram_wdata = w_refill_entry;
        end else if (w_req_fire) begin
            ram_en    = 1'b1;
            ram_addr  = vpn_idx(req_vpn);
        end
    end

    // Control FSM: INIT/FLUSH walk every row once, wrapping the counter back to 0 on the way to IDLE.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= INIT;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                INIT, FLUSH: begin
                    r_cnt <= r_cnt + IDX_W'(1);
                    if (r_cnt == LAST_IDX) begin
                        r_state <= IDLE;
                    end
                end
                IDLE: begin
                    if (flush_req) begin
                        r_state <= FLUSH;
                    end
                end
                default: begin
                    r_state <= INIT;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // S0 -> S1: remember that a read was issued and which tag it must match.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_vld <= 1'b0;
            r_s1_tag <= '0;
        end else begin
            r_s1_vld <= w_req_fire;
            if (w_req_fire) begin
                r_s1_tag <= vpn_tag(req_vpn);
            end
        end
    end

    // S1 -> response: register the compare; PPN is forced to zero on a miss.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_resp_valid <= 1'b0;
            r_resp_hit   <= 1'b0;
            r_resp_ppn   <= '0;
        end else begin
            r_resp_valid <= r_s1_vld;
            r_resp_hit   <= w_s1_hit;
            r_resp_ppn   <= w_s1_hit ? w_rd_entry.ppn : '0;
        end
    end

endmodule

// File: tb/tb_l2_tlb_ctrl.sv
// Purpose: self-checking bench for l2_tlb_ctrl with a behavioural RAM and a VPN->PPN translation model.
// Latency: responses expected 2 cycles after the lookup is accepted.
// Backpressure: bench only issues traffic it expects to be accepted, and checks the readies.
module tb_l2_tlb_ctrl;

    logic        clock        = 1'b0;
    logic        reset_n      = 1'b1;
    logic        req_valid    = 1'b0;
    logic        req_ready;
    logic [26:0] req_vpn      = '0;
    logic        resp_valid;
    logic        resp_hit;
    logic [25:0] resp_ppn;
    logic        refill_valid = 1'b0;
    logic        refill_ready;
    logic [26:0] refill_vpn   = '0;
    logic [25:0] refill_ppn   = '0;
    logic        flush_req    = 1'b0;
    logic        busy;
    logic [8:0]  ram_addr;
    logic        ram_en;
    logic        ram_wmode;
    logic [44:0] ram_wdata;
    logic [44:0] ram_rdata    = '0;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    logic [44:0] mem [512];

    // Translation model: each index slot holds the last VPN installed there and its PPN.
    logic [26:0] m_vpn [int];
    logic [25:0] m_ppn [int];

    typedef struct {
        int          c;
        logic        h;
        logic [25:0] p;
    } resp_t;

    l2_tlb_ctrl dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_vpn      (req_vpn),
        .resp_valid   (resp_valid),
        .resp_hit     (resp_hit),
        .resp_ppn     (resp_ppn),
        .refill_valid (refill_valid),
        .refill_ready (refill_ready),
        .refill_vpn   (refill_vpn),
        .refill_ppn   (refill_ppn),
        .flush_req    (flush_req),
        .busy         (busy),
        .ram_addr     (ram_addr),
        .ram_en       (ram_en),
        .ram_wmode    (ram_wmode),
        .ram_wdata    (ram_wdata),
        .ram_rdata    (ram_rdata)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Single-port RAM, 1-cycle read latency, read data held between reads.
    always @(posedge clock) begin
        if (ram_en) begin
            if (ram_wmode) mem[ram_addr] <= ram_wdata;
            else           ram_rdata     <= mem[ram_addr];
        end
    end

    function automatic logic exp_hit(input logic [26:0] v);
        int idx;
        idx = int'(v[8:0]);
        return m_vpn.exists(idx) && (m_vpn[idx] == v);
    endfunction

    function automatic logic [25:0] exp_ppn(input logic [26:0] v);
        int idx;
        idx = int'(v[8:0]);
        if (m_vpn.exists(idx) && (m_vpn[idx] == v)) return m_ppn[idx];
        return '0;
    endfunction

    function automatic logic [26:0] small_vpn();
        int t;
        int i;
        t = $urandom_range(0, 2);
        i = $urandom_range(0, 5);
        return {18'(t), 9'(i)};
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_refill(input logic [26:0] v, input logic [25:0] p);
        refill_valid = 1'b1;
        refill_vpn   = v;
        refill_ppn   = p;
        step();
        refill_valid = 1'b0;
        m_vpn[int'(v[8:0])] = v;
        m_ppn[int'(v[8:0])] = p;
    endtask

    task automatic do_lookup(input logic [26:0] v, output bit got, output logic hit,
                             output logic [25:0] ppn, output int lat);
        int t0;
        req_valid = 1'b1;
        req_vpn   = v;
        t0        = cyc;
        step();
        req_valid = 1'b0;
        got = 0; hit = 1'b0; ppn = '0; lat = -1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            if (resp_valid && !got) begin
                got = 1; hit = resp_hit; ppn = resp_ppn; lat = cyc - t0;
            end
        end
        step();
    endtask

    task automatic run_sweep(output int n, output int bad, output logic rdy);
        n = 0; bad = 0; rdy = 1'b0;
        for (int i = 0; i < 1100; i++) begin
            @(negedge clock);
            if (!busy) begin
                rdy = req_ready;
                break;
            end
            if (!(ram_en === 1'b1 && ram_wmode === 1'b1 && ram_addr === 9'(n) && ram_wdata === 45'd0)) bad++;
            n++;
        end
        step();
    endtask

    task automatic test_reset();
        int n, bad, lat;
        logic rdy, hit;
        bit got;
        logic [25:0] ppn;
        #1 reset_n = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        n_checks++; if (busy !== 1'b1) $display("FAIL reset_busy got=%b want=1", busy); else n_pass++;
        n_checks++; if (req_ready !== 1'b0) $display("FAIL reset_req_ready got=%b want=0", req_ready); else n_pass++;
        n_checks++; if (refill_ready !== 1'b0) $display("FAIL reset_refill_ready got=%b want=0", refill_ready); else n_pass++;
        n_checks++; if (resp_valid !== 1'b0) $display("FAIL reset_resp_valid got=%b want=0", resp_valid); else n_pass++;
        n_checks++; if (resp_hit !== 1'b0) $display("FAIL reset_resp_hit got=%b want=0", resp_hit); else n_pass++;
        n_checks++; if (resp_ppn !== 26'd0) $display("FAIL reset_resp_ppn got=%h want=0", resp_ppn); else n_pass++;
        n_checks++;
        if (ram_en !== 1'b1 || ram_wmode !== 1'b1 || ram_addr !== 9'd0 || ram_wdata !== 45'd0)
            $display("FAIL reset_ram_port got en=%b wm=%b addr=%h wd=%h want write 0 to 0", ram_en, ram_wmode, ram_addr, ram_wdata);
        else n_pass++;
        @(posedge clock);
        #1 reset_n = 1'b1;
        run_sweep(n, bad, rdy);
        n_checks++; if (n !== 512) $display("FAIL init_sweep_len got=%0d want=512", n); else n_pass++;
        n_checks++; if (bad !== 0) $display("FAIL init_sweep_writes bad_cycles=%0d want=0", bad); else n_pass++;
        n_checks++; if (rdy !== 1'b1) $display("FAIL init_done_req_ready got=%b want=1", rdy); else n_pass++;
        do_lookup(27'h0000123, got, hit, ppn, lat);
        n_checks++; if (!got || lat !== 2) $display("FAIL init_lookup_latency got=%0d want=2", lat); else n_pass++;
        n_checks++; if (hit !== 1'b0 || ppn !== 26'd0) $display("FAIL init_lookup_miss got hit=%b ppn=%h want 0/0", hit, ppn); else n_pass++;
    endtask

    task automatic test_refill_lookup();
        int lat;
        logic hit, e_hit;
        bit got;
        logic [25:0] ppn, e_ppn;
        do_refill(27'h1ABCD05, 26'h2345678);
        e_hit = exp_hit(27'h1ABCD05);
        e_ppn = exp_ppn(27'h1ABCD05);
        do_lookup(27'h1ABCD05, got, hit, ppn, lat);
        n_checks++; if (!got || lat !== 2) $display("FAIL refill_lookup_latency got=%0d want=2", lat); else n_pass++;
        n_checks++; if (hit !== e_hit) $display("FAIL refill_lookup_hit got=%b want=%b", hit, e_hit); else n_pass++;
        n_checks++; if (ppn !== e_ppn) $display("FAIL refill_lookup_ppn got=%h want=%h", ppn, e_ppn); else n_pass++;
    endtask

    task automatic test_alias();
        int lat;
        logic hit, e_hit;
        bit got;
        logic [25:0] ppn, e_ppn;
        e_hit = exp_hit(27'h0000105);
        e_ppn = exp_ppn(27'h0000105);
        do_lookup(27'h0000105, got, hit, ppn, lat);
        n_checks++; if (!got || hit !== e_hit) $display("FAIL alias_hit got=%b want=%b", hit, e_hit); else n_pass++;
        n_checks++; if (ppn !== e_ppn) $display("FAIL alias_ppn got=%h want=%h", ppn, e_ppn); else n_pass++;
    endtask

    task automatic test_collision();
        logic [26:0] v;
        logic [25:0] p, e_ppn;
        logic e_hit;
        int t0, lat;
        bit got;
        v = 27'h0F0F0AA;
        p = 26'h1234567;
        refill_valid = 1'b1; refill_vpn = v; refill_ppn = p;
        req_valid    = 1'b1; req_vpn    = v;
        #1;
        n_checks++; if (req_ready !== 1'b0) $display("FAIL collide_req_ready got=%b want=0", req_ready); else n_pass++;
        n_checks++; if (refill_ready !== 1'b1) $display("FAIL collide_refill_ready got=%b want=1", refill_ready); else n_pass++;
        step();
        refill_valid = 1'b0;
        m_vpn[int'(v[8:0])] = v;
        m_ppn[int'(v[8:0])] = p;
        #1;
        n_checks++; if (req_ready !== 1'b1) $display("FAIL collide_retry_ready got=%b want=1", req_ready); else n_pass++;
        e_hit = exp_hit(v);
        e_ppn = exp_ppn(v);
        t0 = cyc;
        step();
        req_valid = 1'b0;
        got = 0; lat = -1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            if (resp_valid && !got) begin
                got = 1; lat = cyc - t0;
                n_checks++;
                if (resp_hit !== e_hit || resp_ppn !== e_ppn)
                    $display("FAIL collide_resp got hit=%b ppn=%h want %b/%h", resp_hit, resp_ppn, e_hit, e_ppn);
                else n_pass++;
            end
        end
        n_checks++; if (lat !== 2) $display("FAIL collide_latency got=%0d want=2", lat); else n_pass++;
        step();
    endtask

    task automatic test_flush();
        logic [26:0] v [3];
        logic e_hit, hit;
        logic [25:0] e_ppn, ppn;
        int n, bad, rr_bad, nresp, lat;
        bit got;
        for (int i = 0; i < 3; i++) begin
            v[i] = {18'($urandom), 9'(17 + i)};
            do_refill(v[i], 26'($urandom) | 26'd1);
        end
        e_hit = exp_hit(v[0]);
        e_ppn = exp_ppn(v[0]);
        req_valid = 1'b1; req_vpn = v[0];
        step();
        req_valid = 1'b0;
        flush_req = 1'b1;
        #1;
        n_checks++; if (refill_ready !== 1'b0) $display("FAIL flush_cycle_refill_ready got=%b want=0", refill_ready); else n_pass++;
        n_checks++; if (req_ready !== 1'b0) $display("FAIL flush_cycle_req_ready got=%b want=0", req_ready); else n_pass++;
        step();
        m_vpn.delete();
        m_ppn.delete();
        n = 0; bad = 0; rr_bad = 0; nresp = 0; got = 0; hit = 1'b0; ppn = '0;
        for (int i = 0; i < 1100; i++) begin
            flush_req    = (n == 100);
            refill_valid = (n >= 10 && n < 500);
            refill_vpn   = v[1];
            refill_ppn   = 26'h3FFFFFF;
            @(negedge clock);
            if (resp_valid) begin
                nresp++;
                if (n == 0) begin got = 1; hit = resp_hit; ppn = resp_ppn; end
            end
            if (!busy) break;
            if (refill_ready !== 1'b0 || req_ready !== 1'b0) rr_bad++;
            if (!(ram_en === 1'b1 && ram_wmode === 1'b1 && ram_addr === 9'(n) && ram_wdata === 45'd0)) bad++;
            n++;
            @(posedge clock);
            #1;
        end
        flush_req = 1'b0;
        refill_valid = 1'b0;
        step();
        n_checks++; if (n !== 512) $display("FAIL flush_busy_len got=%0d want=512", n); else n_pass++;
        n_checks++; if (bad !== 0) $display("FAIL flush_sweep_writes bad_cycles=%0d want=0", bad); else n_pass++;
        n_checks++; if (rr_bad !== 0) $display("FAIL flush_ready_low bad_cycles=%0d want=0", rr_bad); else n_pass++;
        n_checks++; if (nresp !== 1 || !got) $display("FAIL flush_inflight_resp count=%0d want=1 in first flush cycle", nresp); else n_pass++;
        n_checks++; if (hit !== e_hit || ppn !== e_ppn) $display("FAIL flush_inflight_value got %b/%h want %b/%h", hit, ppn, e_hit, e_ppn); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            e_hit = exp_hit(v[i]);
            e_ppn = exp_ppn(v[i]);
            do_lookup(v[i], got, hit, ppn, lat);
            n_checks++;
            if (!got || hit !== e_hit || ppn !== e_ppn)
                $display("FAIL flush_post_lookup%0d got=%0b hit=%b ppn=%h want %b/%h", i, got, hit, ppn, e_hit, e_ppn);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        resp_t exp_q[$];
        resp_t obs_q[$];
        logic rq, rf;
        logic [26:0] vq, vf;
        logic [25:0] pf;
        for (int i = 0; i < 12; i++) do_refill(small_vpn(), 26'($urandom));
        for (int c = 0; c < 200; c++) begin
            rq = ($urandom_range(0, 3) != 0);
            rf = ($urandom_range(0, 3) == 0);
            vq = small_vpn();
            vf = small_vpn();
            pf = 26'($urandom);
            req_valid = rq; req_vpn = vq;
            refill_valid = rf; refill_vpn = vf; refill_ppn = pf;
            #1;
            n_checks++; if (req_ready !== !rf) $display("FAIL b2b_req_ready c=%0d got=%b want=%b", c, req_ready, !rf); else n_pass++;
            n_checks++; if (refill_ready !== 1'b1) $display("FAIL b2b_refill_ready c=%0d got=%b want=1", c, refill_ready); else n_pass++;
            if (rq && !rf) exp_q.push_back('{cyc + 2, exp_hit(vq), exp_ppn(vq)});
            if (rf) begin
                m_vpn[int'(vf[8:0])] = vf;
                m_ppn[int'(vf[8:0])] = pf;
            end
            @(negedge clock);
            if (resp_valid) obs_q.push_back('{cyc, resp_hit, resp_ppn});
            @(posedge clock);
            #1;
        end
        req_valid = 1'b0;
        refill_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            if (resp_valid) obs_q.push_back('{cyc, resp_hit, resp_ppn});
            @(posedge clock);
            #1;
        end
        n_checks++; if (obs_q.size() !== exp_q.size()) $display("FAIL b2b_resp_count got=%0d want=%0d", obs_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i].c !== exp_q[i].c || obs_q[i].h !== exp_q[i].h || obs_q[i].p !== exp_q[i].p)
                $display("FAIL b2b_resp%0d got cyc=%0d hit=%b ppn=%h want cyc=%0d hit=%b ppn=%h",
                         i, obs_q[i].c, obs_q[i].h, obs_q[i].p, exp_q[i].c, exp_q[i].h, exp_q[i].p);
            else n_pass++;
        end
    endtask

    task automatic test_async_reset();
        bit found, got;
        int n, bad, nresp, lat;
        logic rdy, hit;
        logic [25:0] ppn;
        flush_req = 1'b1;
        step();
        flush_req = 1'b0;
        m_vpn.delete();
        m_ppn.delete();
        found = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clock);
            if (busy === 1'b1 && ram_addr === 9'd200) begin found = 1; break; end
        end
        n_checks++; if (!found) $display("FAIL arst_reach_200 got=timeout want=counter 200"); else n_pass++;
        #1 reset_n = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b1) $display("FAIL arst_busy got=%b want=1", busy); else n_pass++;
        n_checks++; if (req_ready !== 1'b0 || refill_ready !== 1'b0) $display("FAIL arst_readies got=%b%b want=00", req_ready, refill_ready); else n_pass++;
        n_checks++; if (resp_valid !== 1'b0 || resp_hit !== 1'b0 || resp_ppn !== 26'd0) $display("FAIL arst_resp got=%b/%b/%h want 0", resp_valid, resp_hit, resp_ppn); else n_pass++;
        n_checks++;
        if (ram_en !== 1'b1 || ram_wmode !== 1'b1 || ram_addr !== 9'd0 || ram_wdata !== 45'd0)
            $display("FAIL arst_ram_port got en=%b wm=%b addr=%h wd=%h want write 0 to 0", ram_en, ram_wmode, ram_addr, ram_wdata);
        else n_pass++;
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        run_sweep(n, bad, rdy);
        n_checks++; if (n !== 512 || bad !== 0) $display("FAIL arst_resweep got len=%0d bad=%0d want 512/0", n, bad); else n_pass++;
        n_checks++; if (rdy !== 1'b1) $display("FAIL arst_resweep_ready got=%b want=1", rdy); else n_pass++;

        // A lookup caught in S1 by reset must never produce a response.
        do_refill(27'h0ABC033, 26'h0000DEF);
        req_valid = 1'b1; req_vpn = 27'h0ABC033;
        step();
        req_valid = 1'b0;
        #1 reset_n = 1'b0;
        m_vpn.delete();
        m_ppn.delete();
        nresp = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            if (resp_valid !== 1'b0) nresp++;
        end
        n_checks++; if (nresp !== 0) $display("FAIL arst_discard got=%0d responses want=0", nresp); else n_pass++;
        @(posedge clock);
        #1 reset_n = 1'b1;
        run_sweep(n, bad, rdy);
        n_checks++; if (n !== 512 || bad !== 0) $display("FAIL arst2_resweep got len=%0d bad=%0d want 512/0", n, bad); else n_pass++;
        do_lookup(27'h0ABC033, got, hit, ppn, lat);
        n_checks++;
        if (!got || hit !== exp_hit(27'h0ABC033) || ppn !== exp_ppn(27'h0ABC033))
            $display("FAIL arst_post_lookup got=%0b hit=%b ppn=%h want miss", got, hit, ppn);
        else n_pass++;
    endtask

    initial begin
        logic [63:0] r64;
        for (int i = 0; i < 512; i++) begin
            r64 = {$urandom, $urandom};
            mem[i] = {1'b1, r64[43:0]};
        end
        test_reset();
        test_refill_lookup();
        test_alias();
        test_collision();
        test_flush();
        test_back_to_back();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout want=finish");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/l2_tlb_ctrl.md
Name: l2_tlb_ctrl

Overview:
- Access controller directly upstream of the l2_tlb_ram_0_512x45 macro (single-port, 512x45, 1-cycle read latency).
- Accepts lookups from the L1 TLB miss path and returns hit/miss plus PPN.
- Accepts refill writes from the page-table walker.
- Runs a full-array invalidate sweep after reset and on sfence flush.

Parameters:
- ENTRIES, 512, number of RAM rows; must be a power of 2.
- IDX_W, 9, index width; equals log2(ENTRIES).
- VPN_W, 27, Sv39 virtual page number width.
- PPN_W, 26, stored physical page number width.
- TAG_W, 18, stored tag width; equals VPN_W-IDX_W.

Ports:
- clock  in  1  block clock; the RAM's RW0_clk is tied to the same net.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  lookup request.
- req_ready  out  1  lookup accepted when req_valid&req_ready.
- req_vpn  in  27  lookup VPN.
- resp_valid  out  1  one-cycle response pulse; there is no backpressure.
- resp_hit  out  1  1 = tag match on a valid entry.
- resp_ppn  out  26  PPN on hit; 0 on miss.
- refill_valid  in  1  write request from the PTW.
- refill_ready  out  1  refill accepted when valid&ready.
- refill_vpn  in  27  VPN to install.
- refill_ppn  in  26  PPN to install.
- flush_req  in  1  single-cycle pulse; invalidates all entries.
- busy  out  1  high during an INIT or FLUSH sweep.
- ram_addr  out  9  to RW0_addr.
- ram_en  out  1  to RW0_en.
- ram_wmode  out  1  to RW0_wmode.
- ram_wdata  out  45  to RW0_wdata.
- ram_rdata  in  45  from RW0_rdata; only meaningful in the cycle after a read.

Behaviour:
- Entry format, MSB to LSB: {valid[44], tag[43:26], ppn[25:0]}.
  - index = vpn[8:0].
  - tag = vpn[26:9].
- States:
  - INIT: entered on reset.
  - IDLE
  - FLUSH
  - The FSM and sweep counter are reset asynchronously. All other registers also reset to 0.
- Reset values:
  - resp_valid=0, resp_hit=0, resp_ppn=0.
  - req_ready=0, refill_ready=0.
  - busy=1, because state resets to INIT.
- INIT and FLUSH sweep:
  - ram_en=1, ram_wmode=1, ram_wdata=0, ram_addr=counter.
  - The counter increments by 1 per cycle. Going from 0 to 511 takes 512 cycles.
  - At counter=511 the counter wraps to 0 and the next state is IDLE.
  - busy drops in the first IDLE cycle.
  - While reset_n is low, the RAM port shows a write of 0 to index 0. This is permitted because it is idempotent.
- FLUSH entry:
  - flush_req seen in IDLE moves to FLUSH on the next edge. The first sweep write occurs in the first FLUSH cycle.
  - flush_req during INIT or FLUSH is ignored. The sweep is not restarted.
- Request ready:
  - req_ready = (state==IDLE) & ~flush_req & ~refill_valid.
  - refill_ready = (state==IDLE) & ~flush_req.
  - Priority: flush > refill > lookup.
- RAM port in IDLE:
  - Refill accepted: ram_en=1, ram_wmode=1, ram_addr=refill_vpn[8:0], ram_wdata={1, refill_vpn[26:9], refill_ppn}.
  - Lookup accepted (S0): ram_en=1, ram_wmode=0, ram_addr=req_vpn[8:0]. The tag is registered into S1.
  - Otherwise ram_en=0.
- Lookup pipeline:
  - S1 compares ram_rdata[44] & (ram_rdata[43:26]==s1_tag).
  - The result is registered, so resp_valid is asserted exactly 2 cycles after acceptance.
  - Back-to-back lookups are accepted every cycle, giving 1 response per cycle.
- Read/write ordering:
  - A lookup reflects the RAM contents at its S0 cycle.
  - A refill to the same index accepted in the lookup's S1 cycle does not change that lookup's response.
- In-flight lookups: a lookup in S1 when FLUSH begins still produces its response normally.
- Reset mid-operation:
  - An in-flight response is discarded.
  - The FSM restarts INIT at index 0.
- Combinational outputs: ram_* and the ready signals are combinational from state and inputs. No other outputs have combinational input-to-output paths.

Decomposition:
- Package l2_tlb_pkg holds:
  - the IDX_W, TAG_W and PPN_W constants;
  - a packed struct l2_tlb_entry_t {valid, tag, ppn} of 45 bits;
  - enum state_e {INIT, IDLE, FLUSH}.
- Single module; no sub-module is needed.
- The RAM macro is instantiated by the parent, not inside this block.

Test Plan:
- Reset release: exactly 512 write cycles to addresses 0..511 with wdata=0, then busy=0 and req_ready=1. A lookup of vpn 0x0000123 returns resp_hit=0 and resp_ppn=0.
- Refill then lookup: refill vpn=0x1ABCD05, ppn=0x2345678, then look up the same vpn. resp_valid pulses 2 cycles after acceptance with hit=1 and ppn=0x2345678.
- Aliasing: a lookup of vpn=0x0000105 (same index 0x105, different tag) after the refill above returns hit=0.
- Collision: refill_valid and req_valid in the same cycle. The refill is accepted, req_ready=0, and the lookup is accepted on the next cycle and hits.
- Flush: flush_req after 3 refills gives busy=1 for 512 cycles and refill_ready=0 during the sweep. Afterwards, all 3 VPNs miss. A lookup issued the cycle before flush_req still reports its hit.
- Async reset: assert reset_n low at FLUSH counter=200. Required: outputs go to reset values immediately, and after release the INIT sweep restarts from address 0.
